// File: rtl/sram_port_arbiter.sv
// sram_port_arbiter
//   Arbitrates NUM_CH GPU-side masters onto a single SRAM port. One command
//   is granted per cycle, either round-robin or forced to a priority channel.
//   The granted command is registered onto the SRAM pins. Read data is routed
//   back to the issuing channel RD_LATENCY cycles after the read strobe.
//
// Ports
//   clk, n_rst             clock (rising edge), async active-low reset
//   ch_req                 per-channel request
//   ch_read_enable         per-channel read op
//   ch_write_enable        per-channel write op
//   ch_address             packed per-channel addresses, ch i at [i*ADDR_W +: ADDR_W]
//   ch_write_data          packed per-channel write data, ch i at [i*DATA_W +: DATA_W]
//   prio_en, prio_ch       force mode: only prio_ch may be granted
//   ch_grant               one-hot combinational grant (accepted at this edge)
//   ch_rd_valid            one-hot read-return strobe
//   ch_read_data           shared read-return data (sram_read_data passthrough)
//   read_enable            registered SRAM read strobe
//   write_enable           registered SRAM write strobe
//   address, write_data    registered SRAM address / write data
//   sram_read_data         SRAM read data
//   op_err                 sticky: a granted command had both read and write set

module sram_port_arbiter #(
  parameter int NUM_CH     = 4,
  parameter int ADDR_W     = 24,
  parameter int DATA_W     = 1536,
  parameter int RD_LATENCY = 2
) (
  input  logic                       clk,
  input  logic                       n_rst,
  input  logic [NUM_CH-1:0]          ch_req,
  input  logic [NUM_CH-1:0]          ch_read_enable,
  input  logic [NUM_CH-1:0]          ch_write_enable,
  input  logic [NUM_CH*ADDR_W-1:0]   ch_address,
  input  logic [NUM_CH*DATA_W-1:0]   ch_write_data,
  input  logic                       prio_en,
  input  logic [$clog2(NUM_CH)-1:0]  prio_ch,
  output logic [NUM_CH-1:0]          ch_grant,
  output logic [NUM_CH-1:0]          ch_rd_valid,
  output logic [DATA_W-1:0]          ch_read_data,
  output logic                       read_enable,
  output logic                       write_enable,
  output logic [ADDR_W-1:0]          address,
  output logic [DATA_W-1:0]          write_data,
  input  logic [DATA_W-1:0]          sram_read_data,
  output logic                       op_err
);

  localparam int CH_W = $clog2(NUM_CH);

  logic [NUM_CH-1:0] eligible;
  logic              found;
  logic [CH_W-1:0]   gnt_idx;
  logic              grant_any;
  logic              sel_rd;
  logic              sel_wr;
  logic [ADDR_W-1:0] sel_addr;
  logic [DATA_W-1:0] sel_data;

  logic [CH_W-1:0]   rr_ptr;
  logic [CH_W-1:0]   rd_ch;

  // Tag pipe: stage 0 is loaded from the registered read strobe, so the last
  // stage lines up with SRAM data RD_LATENCY cycles after read_enable.
  logic [RD_LATENCY-1:0]           tag_vld;
  logic [RD_LATENCY-1:0][CH_W-1:0] tag_ch;

  // Arbitration. Round-robin is two passes: first eligible channel at or
  // above rr_ptr, otherwise the lowest eligible channel (which wraps).
  always_comb begin
    eligible = ch_req & (ch_read_enable | ch_write_enable);
    found    = 1'b0;
    gnt_idx  = '0;
    if (prio_en) begin
      if ((int'(prio_ch) < NUM_CH) && eligible[prio_ch]) begin
        found   = 1'b1;
        gnt_idx = prio_ch;
      end
    end else begin
      for (int i = 0; i < NUM_CH; i++) begin
        if (!found && eligible[i] && (CH_W'(i) >= rr_ptr)) begin
          found   = 1'b1;
          gnt_idx = CH_W'(i);
        end
      end
      for (int i = 0; i < NUM_CH; i++) begin
        if (!found && eligible[i]) begin
          found   = 1'b1;
          gnt_idx = CH_W'(i);
        end
      end
    end
  end

  // Grant decode and command mux. Grant is masked during reset.
  always_comb begin
    ch_grant  = '0;
    sel_rd    = 1'b0;
    sel_wr    = 1'b0;
    sel_addr  = '0;
    sel_data  = '0;
    grant_any = found & n_rst;
    for (int i = 0; i < NUM_CH; i++) begin
      if (found && (gnt_idx == CH_W'(i))) begin
        ch_grant[i] = n_rst;
        sel_rd      = ch_read_enable[i];
        sel_wr      = ch_write_enable[i];
        sel_addr    = ch_address[i*ADDR_W +: ADDR_W];
        sel_data    = ch_write_data[i*DATA_W +: DATA_W];
      end
    end
  end

  always_ff @(posedge clk or negedge n_rst) begin
    if (!n_rst) begin
      read_enable  <= 1'b0;
      write_enable <= 1'b0;
      address      <= '0;
      write_data   <= '0;
      op_err       <= 1'b0;
      rr_ptr       <= '0;
      rd_ch        <= '0;
      tag_vld      <= '0;
      tag_ch       <= '0;
    end else begin
      // A command with both ops set is executed as a write.
      read_enable  <= grant_any & sel_rd & ~sel_wr;
      write_enable <= grant_any & sel_wr;
      rd_ch        <= gnt_idx;
      if (grant_any) begin
        address    <= sel_addr;
        write_data <= sel_data;
        rr_ptr     <= (gnt_idx == CH_W'(NUM_CH - 1)) ? '0 : gnt_idx + CH_W'(1);
        if (sel_rd && sel_wr) begin
          op_err <= 1'b1;
        end
      end
      tag_vld[0] <= read_enable;
      tag_ch[0]  <= rd_ch;
      for (int s = 1; s < RD_LATENCY; s++) begin
        tag_vld[s] <= tag_vld[s-1];
        tag_ch[s]  <= tag_ch[s-1];
      end
    end
  end

  always_comb begin
    ch_rd_valid = '0;
    for (int i = 0; i < NUM_CH; i++) begin
      ch_rd_valid[i] = tag_vld[RD_LATENCY-1] && (tag_ch[RD_LATENCY-1] == CH_W'(i));
    end
  end

  assign ch_read_data = sram_read_data;

endmodule

// File: tb/tb_sram_port_arbiter.sv
module tb_sram_port_arbiter;

  localparam int NUM_CH = 4;
  localparam int ADDR_W = 24;
  localparam int DATA_W = 32;
  localparam int RD_LAT = 2;
  localparam logic [31:0] RD_BASE = 32'hD000_0000;

  logic                      clk;
  logic                      n_rst;
  logic [NUM_CH-1:0]         ch_req;
  logic [NUM_CH-1:0]         ch_read_enable;
  logic [NUM_CH-1:0]         ch_write_enable;
  logic [NUM_CH*ADDR_W-1:0]  ch_address;
  logic [NUM_CH*DATA_W-1:0]  ch_write_data;
  logic                      prio_en;
  logic [1:0]                prio_ch;
  logic [NUM_CH-1:0]         ch_grant;
  logic [NUM_CH-1:0]         ch_rd_valid;
  logic [DATA_W-1:0]         ch_read_data;
  logic                      read_enable;
  logic                      write_enable;
  logic [ADDR_W-1:0]         address;
  logic [DATA_W-1:0]         write_data;
  logic [DATA_W-1:0]         sram_read_data;
  logic                      op_err;

  logic [31:0] cyc;
  int checks;
  int failures;

  typedef struct {
    logic        re;
    logic        we;
    logic [23:0] addr;
    logic [31:0] data;
  } cmd_t;

  typedef struct {
    logic [3:0]  vld;
    logic [31:0] data;
  } ret_t;

  cmd_t cmd_q[$];
  ret_t ret_q[$];
  cmd_t mc;
  ret_t mr;

  sram_port_arbiter #(
    .NUM_CH(NUM_CH), .ADDR_W(ADDR_W), .DATA_W(DATA_W), .RD_LATENCY(RD_LAT)
  ) dut (
    .clk(clk),
    .n_rst(n_rst),
    .ch_req(ch_req),
    .ch_read_enable(ch_read_enable),
    .ch_write_enable(ch_write_enable),
    .ch_address(ch_address),
    .ch_write_data(ch_write_data),
    .prio_en(prio_en),
    .prio_ch(prio_ch),
    .ch_grant(ch_grant),
    .ch_rd_valid(ch_rd_valid),
    .ch_read_data(ch_read_data),
    .read_enable(read_enable),
    .write_enable(write_enable),
    .address(address),
    .write_data(write_data),
    .sram_read_data(sram_read_data),
    .op_err(op_err)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial cyc = '0;
  always @(posedge clk) cyc <= cyc + 32'd1;

  // SRAM model: data is a function of the cycle number, so the expected
  // return value follows from the issue cycle alone.
  assign sram_read_data = RD_BASE + cyc;

  task automatic chk(input string name, input logic [63:0] got, input logic [63:0] exp);
    checks++;
    if (got !== exp) begin
      failures++;
      $display("FAIL %s got=%0h exp=%0h (t=%0t)", name, got, exp, $time);
    end
  endtask

  task automatic set_ch(input int i, input logic req, input logic rd, input logic wr,
                        input logic [23:0] a, input logic [31:0] d);
    ch_req[i]                  = req;
    ch_read_enable[i]          = rd;
    ch_write_enable[i]         = wr;
    ch_address[i*ADDR_W +: ADDR_W] = a;
    ch_write_data[i*DATA_W +: DATA_W] = d;
  endtask

  task automatic clr_all();
    ch_req          = '0;
    ch_read_enable  = '0;
    ch_write_enable = '0;
  endtask

  task automatic next_cycle();
    @(posedge clk);
    #1;
  endtask

  // Check the grant of the current cycle and queue the expected SRAM command
  // (next cycle) and read return (RD_LAT+1 cycles after the grant).
  task automatic expect_cycle(input string name, input logic [3:0] g, input logic re,
                              input logic we, input logic [23:0] a, input logic [31:0] d);
    cmd_t c;
    ret_t r;
    @(negedge clk);
    chk(name, ch_grant, g);
    if (g != 4'b0) begin
      c.re = re; c.we = we; c.addr = a; c.data = d;
      cmd_q.push_back(c);
      if (re) begin
        r.vld  = g;
        r.data = RD_BASE + cyc + 32'(RD_LAT + 1);
        ret_q.push_back(r);
      end
    end
    next_cycle();
  endtask

  // Monitor: compares SRAM commands and read returns against the scoreboard.
  always @(negedge clk) begin
    if (n_rst) begin
      if (read_enable || write_enable) begin
        if (cmd_q.size() == 0) begin
          chk("cmd_unexpected", {read_enable, write_enable}, 2'b00);
        end else begin
          mc = cmd_q.pop_front();
          chk("cmd_re", read_enable, mc.re);
          chk("cmd_we", write_enable, mc.we);
          chk("cmd_addr", address, mc.addr);
          if (mc.we) chk("cmd_wdata", write_data, mc.data);
        end
      end
      if (ch_rd_valid != '0) begin
        if (ret_q.size() == 0) begin
          chk("rd_unexpected", ch_rd_valid, 4'b0);
        end else begin
          mr = ret_q.pop_front();
          chk("rd_valid", ch_rd_valid, mr.vld);
          chk("rd_data", ch_read_data, mr.data);
        end
      end
    end
  end

  initial begin
    #200000;
    $display("FAIL watchdog timeout");
    $fatal(1, "watchdog");
  end

  initial begin
    checks   = 0;
    failures = 0;
    n_rst    = 1'b1;
    prio_en  = 1'b0;
    prio_ch  = 2'd0;
    ch_address    = '0;
    ch_write_data = '0;
    clr_all();

    // Reset state, including grant masking while a request is pending.
    #2 n_rst = 1'b0;
    #1;
    set_ch(0, 1'b1, 1'b1, 1'b0, 24'h000010, 32'h0);
    #1;
    chk("rst_grant", ch_grant, 4'b0);
    chk("rst_re", read_enable, 1'b0);
    chk("rst_we", write_enable, 1'b0);
    chk("rst_addr", address, 24'h0);
    chk("rst_wdata", write_data, 32'h0);
    chk("rst_operr", op_err, 1'b0);
    chk("rst_rdvalid", ch_rd_valid, 4'b0);
    clr_all();
    next_cycle();
    next_cycle();
    n_rst = 1'b1;
    next_cycle();

    // Round-robin over four continuous writers starting from rr_ptr=0.
    for (int i = 0; i < NUM_CH; i++)
      set_ch(i, 1'b1, 1'b0, 1'b1, 24'h000100 + 24'(i), 32'hA000_0000 + 32'(i));
    for (int k = 0; k < 5; k++) begin
      int c;
      c = k % NUM_CH;
      expect_cycle("rr_grant", 4'(1 << c), 1'b0, 1'b1, 24'h000100 + 24'(c),
                   32'hA000_0000 + 32'(c));
    end
    clr_all();

    // Idle: no grant, strobes drop, address holds, rr_ptr (=1) unchanged.
    expect_cycle("idle_grant", 4'b0, 1'b0, 1'b0, 24'h0, 32'h0);
    expect_cycle("idle_grant", 4'b0, 1'b0, 1'b0, 24'h0, 32'h0);
    @(negedge clk);
    chk("idle_re", read_enable, 1'b0);
    chk("idle_we", write_enable, 1'b0);
    chk("idle_addr_hold", address, 24'h000100);
    next_cycle();
    set_ch(0, 1'b1, 1'b0, 1'b1, 24'h000200, 32'hB000_0000);
    set_ch(1, 1'b1, 1'b0, 1'b1, 24'h000201, 32'hB000_0001);
    expect_cycle("rr_after_idle", 4'b0010, 1'b0, 1'b1, 24'h000201, 32'hB000_0001);
    clr_all();

    // Priority override (rr_ptr=2 on entry).
    for (int i = 0; i < NUM_CH; i++)
      set_ch(i, 1'b1, 1'b0, 1'b1, 24'h000300 + 24'(i), 32'hC000_0000 + 32'(i));
    prio_en = 1'b1;
    prio_ch = 2'd2;
    for (int k = 0; k < 3; k++)
      expect_cycle("prio_grant", 4'b0100, 1'b0, 1'b1, 24'h000302, 32'hC000_0002);
    set_ch(2, 1'b0, 1'b0, 1'b1, 24'h000302, 32'hC000_0002);
    expect_cycle("prio_blocked", 4'b0, 1'b0, 1'b0, 24'h0, 32'h0);
    prio_en = 1'b0;
    expect_cycle("prio_release", 4'b1000, 1'b0, 1'b1, 24'h000303, 32'hC000_0003);
    clr_all();

    // Pipelined reads (rr_ptr=0); ch0 requests with no op and is never granted.
    set_ch(0, 1'b1, 1'b0, 1'b0, 24'h000400, 32'h0);
    set_ch(1, 1'b1, 1'b1, 1'b0, 24'h000401, 32'h0);
    expect_cycle("pipe_rd1", 4'b0010, 1'b1, 1'b0, 24'h000401, 32'h0);
    set_ch(1, 1'b0, 1'b0, 1'b0, 24'h000401, 32'h0);
    set_ch(3, 1'b1, 1'b1, 1'b0, 24'h000403, 32'h0);
    expect_cycle("pipe_rd3", 4'b1000, 1'b1, 1'b0, 24'h000403, 32'h0);
    set_ch(3, 1'b0, 1'b0, 1'b0, 24'h000403, 32'h0);
    for (int k = 0; k < 4; k++)
      expect_cycle("noop_grant", 4'b0, 1'b0, 1'b0, 24'h0, 32'h0);
    clr_all();

    // Both ops set: executed as write, op_err sticky (rr_ptr=0).
    chk("operr_before", op_err, 1'b0);
    set_ch(0, 1'b1, 1'b1, 1'b1, 24'h000055, 32'h0000_0BAD);
    expect_cycle("badop_grant", 4'b0001, 1'b0, 1'b1, 24'h000055, 32'h0000_0BAD);
    clr_all();
    chk("operr_set", op_err, 1'b1);
    for (int k = 0; k < 3; k++) next_cycle();
    chk("operr_sticky", op_err, 1'b1);

    // Reset mid-burst (rr_ptr=1): two reads in flight are discarded.
    set_ch(2, 1'b1, 1'b1, 1'b0, 24'h000600, 32'h0);
    expect_cycle("burst_rd2", 4'b0100, 1'b1, 1'b0, 24'h000600, 32'h0);
    set_ch(2, 1'b0, 1'b0, 1'b0, 24'h000600, 32'h0);
    set_ch(0, 1'b1, 1'b1, 1'b0, 24'h000610, 32'h0);
    expect_cycle("burst_rd0", 4'b0001, 1'b1, 1'b0, 24'h000610, 32'h0);
    @(negedge clk);
    #2 n_rst = 1'b0;
    #1;
    ret_q.delete();
    chk("midrst_grant", ch_grant, 4'b0);
    chk("midrst_re", read_enable, 1'b0);
    chk("midrst_addr", address, 24'h0);
    chk("midrst_operr", op_err, 1'b0);
    chk("midrst_rdvalid", ch_rd_valid, 4'b0);
    clr_all();
    next_cycle();
    @(negedge clk);
    chk("midrst_rdvalid2", ch_rd_valid, 4'b0);
    next_cycle();
    n_rst = 1'b1;
    next_cycle();

    // Post-reset read from ch0 (rr_ptr back to 0).
    set_ch(0, 1'b1, 1'b1, 1'b0, 24'h000010, 32'h0);
    set_ch(1, 1'b1, 1'b1, 1'b0, 24'h000011, 32'h0);
    expect_cycle("post_rst_rd", 4'b0001, 1'b1, 1'b0, 24'h000010, 32'h0);
    clr_all();
    chk("post_rst_operr", op_err, 1'b0);

    for (int k = 0; k < 20; k++) begin
      if (cmd_q.size() == 0 && ret_q.size() == 0) break;
      next_cycle();
    end
    next_cycle();
    chk("cmd_q_drain", 64'(cmd_q.size()), 64'd0);
    chk("ret_q_drain", 64'(ret_q.size()), 64'd0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
